// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register offsets within the
// 16-byte window, the mtimecmp reset value and the 1 us tick helpers.
package mtimer_pkg;

  // Word offsets decoded from mem_addr[3:2]
  localparam logic [1:0] MTIMER_OFF_MTIME_LO    = 2'd0;
  localparam logic [1:0] MTIMER_OFF_MTIME_HI    = 2'd1;
  localparam logic [1:0] MTIMER_OFF_MTIMECMP_LO = 2'd2;
  localparam logic [1:0] MTIMER_OFF_MTIMECMP_HI = 2'd3;

  // mtimecmp starts at its maximum so no interrupt is pending out of reset
  localparam logic [63:0] MTIMER_MTIMECMP_RST = 64'hffff_ffff_ffff_ffff;

  // The 1 us tick fires when the prescaler holds this value
  function automatic int unsigned mtimer_tick_last(input int unsigned fmax_mhz);
    return fmax_mhz - 1;
  endfunction

  // Prescaler counter width; at least one bit even when FMAX_MHz == 1
  function automatic int unsigned mtimer_cnt_w(input int unsigned fmax_mhz);
    return (fmax_mhz > 1) ? $clog2(fmax_mhz) : 1;
  endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides the core clock by FMAX_MHz to produce a one-cycle 1 us tick.
// With FMAX_MHz == 1 the counter stays at zero and tick is constantly high.
module mtimer_prescaler
  import mtimer_pkg::*;
#(
  parameter int unsigned FMAX_MHz = 27
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned    CNT_W = mtimer_cnt_w(FMAX_MHz);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(mtimer_tick_last(FMAX_MHz));

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Count 0..FMAX_MHz-1, wrapping to zero on the tick cycle
  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Prescaler state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mtimer_unit.sv
// Machine timer: cycle/time/mtime/mtimecmp counters for the CSR stage, a
// single-outstanding word port exposing mtime/mtimecmp, and a registered
// timer-pending flag.
// Optional build macro MTIMER_LATCH_HI_EN: a read of mtime[31:0] snapshots
// mtime[63:32] into a shadow that a following read of offset 1 returns,
// giving a torn-free 64-bit read.
module mtimer_unit
  import mtimer_pkg::*;
#(
  parameter int unsigned FMAX_MHz  = 27,
  parameter logic [31:0] BASE_ADDR = 32'hf000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_cmd_start,
  input  logic        mem_cmd_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_cmd_ready,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic [63:0] reg_cycle,
  output logic [63:0] reg_time,
  output logic [63:0] reg_mtime,
  output logic [63:0] reg_mtimecmp,
  output logic        timer_pending
);

  logic        tick;
  logic        accept;
  logic        wr_acc;
  logic        rd_acc;
  logic [1:0]  off;
  logic [63:0] mtime_inc;

  logic [63:0] cycle_q,    cycle_d;
  logic [63:0] time_q,     time_d;
  logic [63:0] mtime_q,    mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        pending_q,  pending_d;
  logic        ready_q,    ready_d;
  logic        rvalid_q,   rvalid_d;
  logic [31:0] rdata_q,    rdata_d;
`ifdef MTIMER_LATCH_HI_EN
  logic [31:0] shadow_q,   shadow_d;
`endif

  // The upstream decoder already matched the window; the remaining address
  // bits and the base value are intentionally not decoded here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:4] ^ BASE_ADDR[31:4], mem_addr[1:0]};

  mtimer_prescaler #(
    .FMAX_MHz (FMAX_MHz)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign off    = mem_addr[3:2];
  assign accept = mem_cmd_start && ready_q;
  assign wr_acc = accept && mem_cmd_write;
  assign rd_acc = accept && !mem_cmd_write;

  // Next-state for counters, software-visible registers and the bus port
  always_comb begin
    cycle_d    = cycle_q + 64'd1;
    time_d     = time_q + {63'd0, tick};
    mtime_inc  = mtime_q + {63'd0, tick};
    mtime_d    = mtime_inc;
    mtimecmp_d = mtimecmp_q;
    pending_d  = (mtime_q >= mtimecmp_q);
    ready_d    = !accept;
    rvalid_d   = rd_acc;
    rdata_d    = rdata_q;
`ifdef MTIMER_LATCH_HI_EN
    shadow_d   = shadow_q;
`endif

    // A write overrides only its own half; the other half keeps the carry
    if (wr_acc) begin
      case (off)
        MTIMER_OFF_MTIME_LO:    mtime_d[31:0]     = mem_wdata;
        MTIMER_OFF_MTIME_HI:    mtime_d[63:32]    = mem_wdata;
        MTIMER_OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = mem_wdata;
        MTIMER_OFF_MTIMECMP_HI: mtimecmp_d[63:32] = mem_wdata;
        default:                mtimecmp_d        = mtimecmp_q;
      endcase
`ifdef MTIMER_LATCH_HI_EN
      if (off == MTIMER_OFF_MTIME_HI) shadow_d = mem_wdata;
`endif
    end

    // Reads return the value held before this edge's tick or write
    if (rd_acc) begin
      case (off)
        MTIMER_OFF_MTIME_LO:    rdata_d = mtime_q[31:0];
`ifdef MTIMER_LATCH_HI_EN
        MTIMER_OFF_MTIME_HI:    rdata_d = shadow_q;
`else
        MTIMER_OFF_MTIME_HI:    rdata_d = mtime_q[63:32];
`endif
        MTIMER_OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
        MTIMER_OFF_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
        default:                rdata_d = rdata_q;
      endcase
`ifdef MTIMER_LATCH_HI_EN
      if (off == MTIMER_OFF_MTIME_LO) shadow_d = mtime_q[63:32];
`endif
    end
  end

  // State registers; reset cancels any pending read response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q    <= '0;
      time_q     <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= MTIMER_MTIMECMP_RST;
      pending_q  <= 1'b0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
`ifdef MTIMER_LATCH_HI_EN
      shadow_q   <= '0;
`endif
    end else begin
      cycle_q    <= cycle_d;
      time_q     <= time_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pending_q  <= pending_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
`ifdef MTIMER_LATCH_HI_EN
      shadow_q   <= shadow_d;
`endif
    end
  end

  assign mem_cmd_ready = ready_q;
  assign mem_rvalid    = rvalid_q;
  assign mem_rdata     = rdata_q;
  assign reg_cycle     = cycle_q;
  assign reg_time      = time_q;
  assign reg_mtime     = mtime_q;
  assign reg_mtimecmp  = mtimecmp_q;
  assign timer_pending = pending_q;

endmodule
